// File: rtl/openram_march_ctrl.sv
// rtl/openram_march_ctrl.sv - March C- style built-in self test controller for an OpenRAM single-port SRAM
//
// Runs one march test per accepted start pulse:
//   M0 up   : write P
//   M1 up   : read P, write ~P
//   M2 down : read ~P, write P
//   M3 down : read P
// followed by READ_LAT drain cycles so the final read is compared before done.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, pattern          run request (accepted only when idle) and background data
//   dout0                   SRAM read data
//   csb0, web0, wmask0,
//   addr0, din0             registered SRAM port-0 controls
//   busy, done              run in progress / run complete (held until next start)
//   fail, fail_addr,
//   fail_elem, fail_data    sticky fail flag and details of the first mismatch
//   err_count               saturating mismatch count
module openram_march_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int READ_LAT    = 1,
    parameter int WMASK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  pattern,
    input  logic [DATA_WIDTH-1:0]  dout0,
    output logic                   csb0,
    output logic                   web0,
    output logic [WMASK_WIDTH-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0]  addr0,
    output logic [DATA_WIDTH-1:0]  din0,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDR_WIDTH-1:0]  fail_addr,
    output logic [1:0]             fail_elem,
    output logic [DATA_WIDTH-1:0]  fail_data,
    output logic [15:0]            err_count
);
    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1_R, S_M1_W, S_M2_R, S_M2_W, S_M3, S_DRAIN, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_t                  state, nxt_state;
    logic [ADDR_WIDTH-1:0]   ptr, nxt_ptr;
    logic [2:0]              drain_cnt, nxt_drain;
    logic [DATA_WIDTH-1:0]   pat;
    logic                    accept;
    logic                    op_rd, op_wr;
    logic [DATA_WIDTH-1:0]   op_data;
    logic [1:0]              op_elem;

    // Read currently on the bus; feeds the compare pipeline one cycle later.
    logic                    cur_rd;
    logic [DATA_WIDTH-1:0]   cur_exp;
    logic [1:0]              cur_elem;

    logic                    pipe_v    [READ_LAT];
    logic [DATA_WIDTH-1:0]   pipe_exp  [READ_LAT];
    logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LAT];
    logic [1:0]              pipe_elem [READ_LAT];

    assign accept = (state == S_IDLE) && start;

    // Decide the next state and the memory operation it performs. The op is
    // registered together with the state so the SRAM pins always reflect the
    // current state's access; nxt_ptr is the address of that access.
    always_comb begin
        nxt_state = state;
        nxt_ptr   = ptr;
        nxt_drain = drain_cnt;
        op_rd     = 1'b0;
        op_wr     = 1'b0;
        op_data   = '0;
        op_elem   = 2'd0;
        case (state)
            S_IDLE: if (start) begin
                nxt_state = S_M0; nxt_ptr = '0; op_wr = 1'b1; op_data = pattern;
            end
            S_M0: if (ptr == ADDR_MAX) begin
                nxt_state = S_M1_R; nxt_ptr = '0; op_rd = 1'b1; op_data = pat; op_elem = 2'd1;
            end else begin
                nxt_ptr = ptr + ADDR_WIDTH'(1); op_wr = 1'b1; op_data = pat;
            end
            S_M1_R: begin
                nxt_state = S_M1_W; op_wr = 1'b1; op_data = ~pat;
            end
            S_M1_W: if (ptr == ADDR_MAX) begin
                nxt_state = S_M2_R; nxt_ptr = ADDR_MAX; op_rd = 1'b1; op_data = ~pat; op_elem = 2'd2;
            end else begin
                nxt_state = S_M1_R; nxt_ptr = ptr + ADDR_WIDTH'(1);
                op_rd = 1'b1; op_data = pat; op_elem = 2'd1;
            end
            S_M2_R: begin
                nxt_state = S_M2_W; op_wr = 1'b1; op_data = pat;
            end
            S_M2_W: if (ptr == '0) begin
                nxt_state = S_M3; nxt_ptr = ADDR_MAX; op_rd = 1'b1; op_data = pat; op_elem = 2'd3;
            end else begin
                nxt_state = S_M2_R; nxt_ptr = ptr - ADDR_WIDTH'(1);
                op_rd = 1'b1; op_data = ~pat; op_elem = 2'd2;
            end
            S_M3: if (ptr == '0) begin
                nxt_state = S_DRAIN; nxt_drain = 3'(READ_LAT - 1);
            end else begin
                nxt_ptr = ptr - ADDR_WIDTH'(1); op_rd = 1'b1; op_data = pat; op_elem = 2'd3;
            end
            S_DRAIN: if (drain_cnt == 3'd0) nxt_state = S_DONE;
                     else nxt_drain = drain_cnt - 3'd1;
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            drain_cnt <= 3'd0;
            pat       <= '0;
            csb0      <= 1'b1;
            web0      <= 1'b1;
            wmask0    <= '0;
            addr0     <= '0;
            din0      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_rd    <= 1'b0;
            cur_exp   <= '0;
            cur_elem  <= 2'd0;
        end else begin
            state     <= nxt_state;
            ptr       <= nxt_ptr;
            drain_cnt <= nxt_drain;
            if (accept) pat <= pattern;
            csb0      <= !(op_rd || op_wr);
            web0      <= !op_wr;
            wmask0    <= op_wr ? '1 : '0;
            addr0     <= (op_rd || op_wr) ? nxt_ptr : '0;
            din0      <= op_wr ? op_data : '0;
            busy      <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            if (accept)                  done <= 1'b0;
            else if (nxt_state == S_DONE) done <= 1'b1;
            cur_rd    <= op_rd;
            cur_exp   <= op_rd ? op_data : '0;
            cur_elem  <= op_elem;
        end
    end

    // Compare pipeline: an entry reaches the last stage in the same cycle the
    // SRAM presents the data for that read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_v[i]    <= 1'b0;
                pipe_exp[i]  <= '0;
                pipe_addr[i] <= '0;
                pipe_elem[i] <= 2'd0;
            end
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 2'd0;
            fail_data <= '0;
            err_count <= 16'd0;
        end else begin
            pipe_v[0]    <= cur_rd;
            pipe_exp[0]  <= cur_exp;
            pipe_addr[0] <= addr0;
            pipe_elem[0] <= cur_elem;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_elem[i] <= pipe_elem[i-1];
            end
            if (accept) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= 2'd0;
                fail_data <= '0;
                err_count <= 16'd0;
            end else if (pipe_v[READ_LAT-1] && (dout0 != pipe_exp[READ_LAT-1])) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= pipe_addr[READ_LAT-1];
                    fail_elem <= pipe_elem[READ_LAT-1];
                    fail_data <= dout0;
                end
            end
        end
    end
endmodule

// File: tb/tb_openram_march_ctrl.sv
// tb/tb_openram_march_ctrl.sv - self-checking bench for openram_march_ctrl (READ_LAT 1 and 3)
module tb_openram_march_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int N  = 256;

    logic clk;
    logic reset_n;
    logic start1, start3;
    logic [DW-1:0] pattern;

    logic [DW-1:0] dout1, din1, fail_data1;
    logic          csb1, web1, busy1, done1, fail1;
    logic [MW-1:0] wmask1;
    logic [AW-1:0] addr1, fail_addr1;
    logic [1:0]    fail_elem1;
    logic [15:0]   err1;

    logic [DW-1:0] dout3, din3, fail_data3;
    logic          csb3, web3, busy3, done3, fail3;
    logic [MW-1:0] wmask3;
    logic [AW-1:0] addr3, fail_addr3;
    logic [1:0]    fail_elem3;
    logic [15:0]   err3;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } op_t;
    typedef struct {
        logic          fail;
        logic [AW-1:0] faddr;
        logic [1:0]    felem;
        logic [DW-1:0] fdata;
        logic [15:0]   err;
        int            busy_n;
    } res_t;

    op_t  op_q[$];
    res_t res_q[$];

    openram_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1), .WMASK_WIDTH(MW)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .pattern(pattern), .dout0(dout1),
        .csb0(csb1), .web0(web1), .wmask0(wmask1), .addr0(addr1), .din0(din1),
        .busy(busy1), .done(done1), .fail(fail1), .fail_addr(fail_addr1),
        .fail_elem(fail_elem1), .fail_data(fail_data1), .err_count(err1));

    openram_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(3), .WMASK_WIDTH(MW)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .pattern(pattern), .dout0(dout3),
        .csb0(csb3), .web0(web3), .wmask0(wmask3), .addr0(addr3), .din0(din3),
        .busy(busy3), .done(done3), .fail(fail3), .fail_addr(fail_addr3),
        .fail_elem(fail_elem3), .fail_data(fail_data3), .err_count(err3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAMs with an optional single stuck-at-0 bit applied on read.
    logic          fault_en;
    logic [AW-1:0] fault_addr;
    int            fault_bit;
    logic [DW-1:0] mem1 [N];
    logic [DW-1:0] mem3 [N];
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd3 [3];

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = v;
        if (fault_en && a == fault_addr) r[fault_bit] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (!csb1 && !web1)
            for (int b = 0; b < MW; b++) if (wmask1[b]) mem1[addr1][b*8 +: 8] <= din1[b*8 +: 8];
        rd1 <= (!csb1 && web1) ? faulty(mem1[addr1], addr1) : '0;
    end
    assign dout1 = rd1;

    always @(posedge clk) begin
        if (!csb3 && !web3)
            for (int b = 0; b < MW; b++) if (wmask3[b]) mem3[addr3][b*8 +: 8] <= din3[b*8 +: 8];
        rd3[0] <= (!csb3 && web3) ? faulty(mem3[addr3], addr3) : '0;
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign dout3 = rd3[2];

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        if (sel == 3) start3 = 1'b0; else start1 = 1'b0;
    endtask

    // Counts busy cycles until done is seen; leaves the caller on that negedge.
    task automatic wait_run(input int sel, output int busy_n, output bit to);
        busy_n = 0;
        to = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (sel == 3 ? busy3 : busy1) busy_n++;
            if (sel == 3 ? done3 : done1) begin to = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic push_result(input logic f, input logic [AW-1:0] fa, input logic [1:0] fe,
                               input logic [DW-1:0] fd, input logic [15:0] ec, input int bn);
        res_t r;
        r.fail = f; r.faddr = fa; r.felem = fe; r.fdata = fd; r.err = ec; r.busy_n = bn;
        res_q.push_back(r);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start1 = 1'b0; start3 = 1'b0; pattern = '0;
        fault_en = 1'b0; fault_addr = '0; fault_bit = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({csb1, web1, wmask1, addr1, din1} !== {1'b1, 1'b1, 4'h0, 8'h00, 32'h0}) begin
            errors++; $display("FAIL reset_bus: got csb=%b web=%b wmask=%h addr=%h din=%h required 1 1 0 00 00000000",
                               csb1, web1, wmask1, addr1, din1);
        end
        checks++;
        if ({busy1, done1, fail1, fail_addr1, fail_elem1, fail_data1, err1} !== '0) begin
            errors++; $display("FAIL reset_status: got busy=%b done=%b fail=%b faddr=%h felem=%0d fdata=%h err=%0d required all zero",
                               busy1, done1, fail1, fail_addr1, fail_elem1, fail_data1, err1);
        end
        checks++;
        if ({csb3, busy3, done3, fail3, err3} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            errors++; $display("FAIL reset_lat3: got csb=%b busy=%b done=%b fail=%b err=%0d required 1 0 0 0 0",
                               csb3, busy3, done3, fail3, err3);
        end
    endtask

    task automatic test_clean_run();
        res_t e; int bn; bit to;
        pattern = 32'hA5A5_5A5A;
        push_result(1'b0, '0, 2'd0, '0, 16'd0, 6*N + 1);
        pulse_start(1);
        wait_run(1, bn, to);
        e = res_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL clean_timeout: done never rose"); end
        checks++; if (bn != e.busy_n) begin errors++; $display("FAIL clean_busy: got %0d cycles required %0d", bn, e.busy_n); end
        checks++; if ({done1, busy1} !== 2'b10) begin errors++; $display("FAIL clean_done: got done=%b busy=%b required 1 0", done1, busy1); end
        checks++;
        if (fail1 !== e.fail || err1 !== e.err || fail_addr1 !== e.faddr || fail_data1 !== e.fdata) begin
            errors++; $display("FAIL clean_status: got fail=%b err=%0d faddr=%h fdata=%h required %b %0d %h %h",
                               fail1, err1, fail_addr1, fail_data1, e.fail, e.err, e.faddr, e.fdata);
        end
        repeat (3) @(negedge clk);
        checks++; if ({done1, busy1} !== 2'b10) begin errors++; $display("FAIL done_held: got done=%b busy=%b required 1 0", done1, busy1); end
    endtask

    task automatic test_bus_order();
        op_t e; int wr_n, rd_n; bit to;
        logic [DW-1:0] p;
        p = 32'h1234_5678;
        pattern = p;
        for (int a = 0; a < N; a++) op_q.push_back({1'b1, AW'(a), p});
        for (int a = 0; a < N; a++) begin
            op_q.push_back({1'b0, AW'(a), p});
            op_q.push_back({1'b1, AW'(a), ~p});
        end
        for (int a = N - 1; a >= 0; a--) begin
            op_q.push_back({1'b0, AW'(a), ~p});
            op_q.push_back({1'b1, AW'(a), p});
        end
        for (int a = N - 1; a >= 0; a--) op_q.push_back({1'b0, AW'(a), p});
        pulse_start(1);
        wr_n = 0; rd_n = 0; to = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (done1) begin to = 1'b0; break; end
            if (!csb1) begin
                if (!web1) wr_n++; else rd_n++;
                checks++;
                if (op_q.size() == 0) begin
                    errors++; $display("FAIL bus_extra: unexpected access addr=%h web=%b", addr1, web1);
                end else begin
                    e = op_q.pop_front();
                    if (web1 !== !e.we || addr1 !== e.addr || (e.we && (din1 !== e.data || wmask1 !== 4'hF))) begin
                        errors++; $display("FAIL bus_op: got we=%b addr=%h din=%h wmask=%h required we=%b addr=%h din=%h",
                                           !web1, addr1, din1, wmask1, e.we, e.addr, e.data);
                    end
                end
            end
            @(negedge clk);
        end
        checks++; if (to) begin errors++; $display("FAIL bus_timeout: done never rose"); end
        checks++; if (wr_n != 3*N) begin errors++; $display("FAIL bus_writes: got %0d required %0d", wr_n, 3*N); end
        checks++; if (rd_n != 3*N) begin errors++; $display("FAIL bus_reads: got %0d required %0d", rd_n, 3*N); end
        checks++; if (op_q.size() != 0) begin errors++; $display("FAIL bus_missing: %0d accesses never seen required 0", op_q.size()); end
        checks++;
        if ({csb1, web1, wmask1, addr1, din1} !== {1'b1, 1'b1, 4'h0, 8'h00, 32'h0}) begin
            errors++; $display("FAIL bus_idle: got csb=%b web=%b wmask=%h addr=%h din=%h required 1 1 0 00 00000000",
                               csb1, web1, wmask1, addr1, din1);
        end
        op_q.delete();
    endtask

    task automatic test_stuck_fault();
        res_t e; int bn; bit to;
        fault_en = 1'b1; fault_addr = 8'h40; fault_bit = 3;
        pattern = 32'hA5A5_5A5A;
        push_result(1'b1, 8'h40, 2'd1, 32'hA5A5_5A52, 16'd2, 6*N + 1);
        pulse_start(1);
        wait_run(1, bn, to);
        e = res_q.pop_front();
        fault_en = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL stuck_timeout: done never rose"); end
        checks++; if (bn != e.busy_n) begin errors++; $display("FAIL stuck_busy: got %0d cycles required %0d", bn, e.busy_n); end
        checks++; if (fail1 !== e.fail) begin errors++; $display("FAIL stuck_fail: got %b required %b", fail1, e.fail); end
        checks++; if (fail_addr1 !== e.faddr) begin errors++; $display("FAIL stuck_addr: got %h required %h", fail_addr1, e.faddr); end
        checks++; if (fail_elem1 !== e.felem) begin errors++; $display("FAIL stuck_elem: got %0d required %0d", fail_elem1, e.felem); end
        checks++; if (fail_data1 !== e.fdata) begin errors++; $display("FAIL stuck_data: got %h required %h", fail_data1, e.fdata); end
        checks++; if (err1 !== e.err) begin errors++; $display("FAIL stuck_count: got %0d required %0d", err1, e.err); end
    endtask

    task automatic test_start_held();
        res_t e; int bn; bit to;
        pattern = 32'h0F0F_F0F0;
        push_result(1'b0, '0, 2'd0, '0, 16'd0, 6*N + 1);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        wait_run(1, bn, to);
        start1 = 1'b0;
        e = res_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL held_timeout: done never rose"); end
        checks++; if (bn != e.busy_n) begin errors++; $display("FAIL held_busy: got %0d cycles required %0d", bn, e.busy_n); end
        checks++;
        if (fail1 !== e.fail || err1 !== e.err) begin
            errors++; $display("FAIL held_status: got fail=%b err=%0d required %b %0d", fail1, err1, e.fail, e.err);
        end
        repeat (3) @(negedge clk);
        checks++; if ({busy1, done1} !== 2'b01) begin errors++; $display("FAIL held_restart: got busy=%b done=%b required 0 1", busy1, done1); end
    endtask

    task automatic test_reset_midrun();
        res_t e; int bn; bit to;
        fault_en = 1'b1; fault_addr = 8'h40; fault_bit = 3;
        pattern = 32'hA5A5_5A5A;
        pulse_start(1);
        repeat (699) @(negedge clk);
        checks++; if ({busy1, fail1} !== 2'b11) begin errors++; $display("FAIL midrun_pre: got busy=%b fail=%b required 1 1", busy1, fail1); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({csb1, web1, wmask1, addr1, din1, busy1, done1} !== {1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL midrun_bus: got csb=%b web=%b wmask=%h addr=%h din=%h busy=%b done=%b required 1 1 0 00 0 0 0",
                               csb1, web1, wmask1, addr1, din1, busy1, done1);
        end
        checks++;
        if ({fail1, fail_addr1, fail_elem1, fail_data1, err1} !== '0) begin
            errors++; $display("FAIL midrun_status: got fail=%b faddr=%h felem=%0d fdata=%h err=%0d required all zero",
                               fail1, fail_addr1, fail_elem1, fail_data1, err1);
        end
        fault_en = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if ({busy1, done1, csb1} !== 3'b001) begin errors++; $display("FAIL midrun_abort: got busy=%b done=%b csb=%b required 0 0 1", busy1, done1, csb1); end
        push_result(1'b0, '0, 2'd0, '0, 16'd0, 6*N + 1);
        pulse_start(1);
        wait_run(1, bn, to);
        e = res_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL rerun_timeout: done never rose"); end
        checks++; if (bn != e.busy_n) begin errors++; $display("FAIL rerun_busy: got %0d cycles required %0d", bn, e.busy_n); end
        checks++;
        if (done1 !== 1'b1 || fail1 !== e.fail || err1 !== e.err) begin
            errors++; $display("FAIL rerun_status: got done=%b fail=%b err=%0d required 1 %b %0d", done1, fail1, err1, e.fail, e.err);
        end
    endtask

    task automatic test_read_lat3();
        res_t e; int bn; bit to;
        pattern = 32'hA5A5_5A5A;
        push_result(1'b0, '0, 2'd0, '0, 16'd0, 6*N + 3);
        pulse_start(3);
        wait_run(3, bn, to);
        e = res_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL lat3_timeout: done never rose"); end
        checks++; if (bn != e.busy_n) begin errors++; $display("FAIL lat3_busy: got %0d cycles required %0d", bn, e.busy_n); end
        checks++;
        if (fail3 !== e.fail || err3 !== e.err) begin
            errors++; $display("FAIL lat3_clean: got fail=%b err=%0d required %b %0d", fail3, err3, e.fail, e.err);
        end
        // Bit 0 of P is 0, so only the ~P reads of M2 see the stuck bit.
        fault_en = 1'b1; fault_addr = 8'hC3; fault_bit = 0;
        push_result(1'b1, 8'hC3, 2'd2, 32'h5A5A_A5A4, 16'd1, 6*N + 3);
        pulse_start(3);
        wait_run(3, bn, to);
        e = res_q.pop_front();
        fault_en = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL lat3f_timeout: done never rose"); end
        checks++; if (bn != e.busy_n) begin errors++; $display("FAIL lat3f_busy: got %0d cycles required %0d", bn, e.busy_n); end
        checks++; if (fail_addr3 !== e.faddr) begin errors++; $display("FAIL lat3f_addr: got %h required %h", fail_addr3, e.faddr); end
        checks++;
        if (fail3 !== e.fail || fail_elem3 !== e.felem || fail_data3 !== e.fdata || err3 !== e.err) begin
            errors++; $display("FAIL lat3f_status: got fail=%b elem=%0d data=%h err=%0d required %b %0d %h %0d",
                               fail3, fail_elem3, fail_data3, err3, e.fail, e.felem, e.fdata, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_bus_order();
        test_stuck_fault();
        test_start_held();
        test_reset_midrun();
        test_read_lat3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
